// File: rtl/board_update_if.sv
// Bundle of board_update control inputs and board/status outputs.
// master drives lock requests and coordinates; slave is the board_update core.
interface board_update_if #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20
);
    logic                      lock_req;
    logic                      board_clear;
    logic [9:0]                ctrlX1;
    logic [9:0]                ctrlX2;
    logic [9:0]                ctrlX3;
    logic [9:0]                ctrlX4;
    logic [9:0]                ctrlY1;
    logic [9:0]                ctrlY2;
    logic [9:0]                ctrlY3;
    logic [9:0]                ctrlY4;
    logic [0:WIDTH*HEIGHT-1]   boardMemory;
    logic                      busy;
    logic                      done;
    logic [2:0]                lines_cleared;
    logic                      conflict;
    logic                      flash_active;
    logic [4:0]                flash_row;

    modport master (
        output lock_req, board_clear,
        output ctrlX1, ctrlX2, ctrlX3, ctrlX4,
        output ctrlY1, ctrlY2, ctrlY3, ctrlY4,
        input  boardMemory, busy, done, lines_cleared, conflict,
        input  flash_active, flash_row
    );

    modport slave (
        input  lock_req, board_clear,
        input  ctrlX1, ctrlX2, ctrlX3, ctrlX4,
        input  ctrlY1, ctrlY2, ctrlY3, ctrlY4,
        output boardMemory, busy, done, lines_cleared, conflict,
        output flash_active, flash_row
    );
endinterface

// File: rtl/board_update.sv
// Locked-cell playfield: merges a 4-cell piece on lock, then collapses full rows bottom-up.
// Optional row flash before each collapse is enabled by defining CLEAR_FLASH_EN.
module board_update #(
    parameter int WIDTH        = 10,
    parameter int HEIGHT       = 20,
    parameter int FLASH_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    board_update_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        SCAN,
`ifdef CLEAR_FLASH_EN
        FLASH,
`endif
        SHIFT,
        DONE
    } state_t;

    // Row pointer is 5 bits and coordinates are 10 bits wide.
    if (HEIGHT > 32 || WIDTH > 1024 || FLASH_CYCLES < 1) begin : g_param_check
        $error("board_update: unsupported parameter set");
    end

    state_t state_reg, state_next;

    logic [0:WIDTH-1] rows_reg  [HEIGHT];
    logic [0:WIDTH-1] mask      [HEIGHT];
    logic [0:WIDTH-1] shift_row [HEIGHT];
    logic [HEIGHT-1:0] row_overlap;

    logic [9:0] px_reg [4];
    logic [9:0] py_reg [4];
    logic [4:0] r_reg;
    logic [2:0] cnt_reg;
    logic       busy_reg;
    logic       done_reg;
    logic [2:0] lines_reg;
    logic       conflict_reg;
    logic       row_full;
    logic       overlap_any;
    logic       flash_active;
    logic [4:0] flash_row;

`ifdef CLEAR_FLASH_EN
    localparam int FC_W = $clog2(FLASH_CYCLES + 1);
    logic [FC_W-1:0] flash_cnt_reg;
`endif

    // Piece mask, collapse candidate and overlap, one row at a time.
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
            assign mask[gi][gj] =
                (px_reg[0] == 10'(gj) && py_reg[0] == 10'(gi)) ||
                (px_reg[1] == 10'(gj) && py_reg[1] == 10'(gi)) ||
                (px_reg[2] == 10'(gj) && py_reg[2] == 10'(gi)) ||
                (px_reg[3] == 10'(gj) && py_reg[3] == 10'(gi));
        end
        if (gi == 0) begin : g_top
            assign shift_row[gi] = '0;
        end else begin : g_lower
            assign shift_row[gi] = (r_reg >= 5'(gi)) ? rows_reg[gi-1] : rows_reg[gi];
        end
        assign row_overlap[gi] = |(rows_reg[gi] & mask[gi]);
        assign bus.boardMemory[gi*WIDTH +: WIDTH] = rows_reg[gi];
    end

    assign row_full    = &rows_reg[r_reg];
    assign overlap_any = |row_overlap;

    always_comb begin
        state_next   = state_reg;
        flash_active = 1'b0;
        flash_row    = 5'd0;
        case (state_reg)
            IDLE:  if (bus.lock_req && !bus.board_clear) state_next = MERGE;
            MERGE: state_next = SCAN;
            SCAN: begin
                if (row_full) begin
`ifdef CLEAR_FLASH_EN
                    state_next = FLASH;
`else
                    state_next = SHIFT;
`endif
                end else if (r_reg == 5'd0) begin
                    state_next = DONE;
                end
            end
`ifdef CLEAR_FLASH_EN
            FLASH: begin
                flash_active = 1'b1;
                flash_row    = r_reg;
                if (flash_cnt_reg == FC_W'(FLASH_CYCLES - 1)) state_next = SHIFT;
            end
`endif
            SHIFT: state_next = SCAN;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            lines_reg    <= 3'd0;
            conflict_reg <= 1'b0;
            r_reg        <= 5'd0;
            cnt_reg      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                px_reg[i] <= '0;
                py_reg[i] <= '0;
            end
            for (int i = 0; i < HEIGHT; i++) rows_reg[i] <= '0;
`ifdef CLEAR_FLASH_EN
            flash_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Clear takes priority over a simultaneous lock request.
                    if (bus.board_clear) begin
                        for (int i = 0; i < HEIGHT; i++) rows_reg[i] <= '0;
                    end else if (bus.lock_req) begin
                        px_reg[0]    <= bus.ctrlX1;
                        px_reg[1]    <= bus.ctrlX2;
                        px_reg[2]    <= bus.ctrlX3;
                        px_reg[3]    <= bus.ctrlX4;
                        py_reg[0]    <= bus.ctrlY1;
                        py_reg[1]    <= bus.ctrlY2;
                        py_reg[2]    <= bus.ctrlY3;
                        py_reg[3]    <= bus.ctrlY4;
                        busy_reg     <= 1'b1;
                        conflict_reg <= 1'b0;
                    end
                end
                MERGE: begin
                    for (int i = 0; i < HEIGHT; i++) rows_reg[i] <= rows_reg[i] | mask[i];
                    conflict_reg <= overlap_any;
                    cnt_reg      <= 3'd0;
                    r_reg        <= 5'(HEIGHT - 1);
                end
                SCAN: begin
                    if (!row_full && r_reg != 5'd0) r_reg <= r_reg - 5'd1;
`ifdef CLEAR_FLASH_EN
                    flash_cnt_reg <= '0;
`endif
                end
`ifdef CLEAR_FLASH_EN
                FLASH: flash_cnt_reg <= flash_cnt_reg + 1'b1;
`endif
                SHIFT: begin
                    // r is kept so the row that dropped into it gets re-checked.
                    for (int i = 0; i < HEIGHT; i++) rows_reg[i] <= shift_row[i];
                    if (cnt_reg != 3'd4) cnt_reg <= cnt_reg + 3'd1;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    lines_reg <= cnt_reg;
                    busy_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.lines_cleared = lines_reg;
    assign bus.conflict      = conflict_reg;
    assign bus.flash_active  = flash_active;
    assign bus.flash_row     = flash_row;

endmodule

// File: tb/tb_board_update.sv
// Directed bench for board_update: merges, row collapses, conflicts, busy drop, clear and reset.
// Expected boards and latencies are hand-computed from the cell coordinates.
module tb_board_update;

`ifdef CLEAR_FLASH_EN
    localparam int FL      = 16;
    localparam int FL_ROW  = 19;
`else
    localparam int FL      = 0;
    localparam int FL_ROW  = 0;
`endif
    localparam int LIMIT = 400;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   lat;
    int   flash_seen;
    int   flash_row_last;
    int   done_cnt;
    logic [0:199] exp_board;

    board_update_if bus ();

    board_update dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_coords(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
        bus.ctrlX1 = 10'(x0); bus.ctrlY1 = 10'(y0);
        bus.ctrlX2 = 10'(x1); bus.ctrlY2 = 10'(y1);
        bus.ctrlX3 = 10'(x2); bus.ctrlY3 = 10'(y2);
        bus.ctrlX4 = 10'(x3); bus.ctrlY4 = 10'(y3);
    endtask

    // Lock a piece and wait for done; lat = cycles from accept edge to done.
    task automatic lock_piece(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
        @(negedge clk);
        set_coords(x0, y0, x1, y1, x2, y2, x3, y3);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        lat = 0;
        flash_seen = 0;
        flash_row_last = 0;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            if (bus.flash_active === 1'b1) begin
                flash_seen++;
                flash_row_last = int'(bus.flash_row);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic clear_board();
        @(negedge clk);
        bus.board_clear = 1'b1;
        @(negedge clk);
        bus.board_clear = 1'b0;
    endtask

    task automatic fill_row19_but_x9();
        lock_piece(0, 19, 1, 19, 2, 19, 3, 19);
        lock_piece(4, 19, 5, 19, 6, 19, 7, 19);
        lock_piece(8, 19, 15, 0, 15, 0, 15, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.lock_req = 1'b0;
        bus.board_clear = 1'b0;
        set_coords(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        check_eq("reset_board", bus.boardMemory, '0);
        check_eq("reset_busy", 200'(bus.busy), 200'(0));
        check_eq("reset_done", 200'(bus.done), 200'(0));
        check_eq("reset_lines", 200'(bus.lines_cleared), 200'(0));
        check_eq("reset_conflict", 200'(bus.conflict), 200'(0));
        check_eq("reset_flash_active", 200'(bus.flash_active), 200'(0));
        check_eq("reset_flash_row", 200'(bus.flash_row), 200'(0));
        rst = 1'b0;

        // O piece on an empty board.
        lock_piece(4, 18, 5, 18, 4, 19, 5, 19);
        exp_board = '0;
        exp_board[184] = 1'b1; exp_board[185] = 1'b1;
        exp_board[194] = 1'b1; exp_board[195] = 1'b1;
        check_eq("o_latency", 200'(lat), 200'(22));
        check_eq("o_board", bus.boardMemory, exp_board);
        check_eq("o_lines", 200'(bus.lines_cleared), 200'(0));
        check_eq("o_conflict", 200'(bus.conflict), 200'(0));
        check_eq("o_busy_at_done", 200'(bus.busy), 200'(0));
        @(negedge clk);
        check_eq("o_done_pulse_width", 200'(bus.done), 200'(0));

        // Single-row clear with a vertical I at x=9.
        clear_board();
        check_eq("clear_board", bus.boardMemory, '0);
        fill_row19_but_x9();
        lock_piece(9, 16, 9, 17, 9, 18, 9, 19);
        exp_board = '0;
        exp_board[179] = 1'b1; exp_board[189] = 1'b1; exp_board[199] = 1'b1;
        check_eq("i1_latency", 200'(lat), 200'(24 + FL));
        check_eq("i1_board", bus.boardMemory, exp_board);
        check_eq("i1_lines", 200'(bus.lines_cleared), 200'(1));
        check_eq("i1_conflict", 200'(bus.conflict), 200'(0));
        check_eq("i1_flash_cycles", 200'(flash_seen), 200'(FL));
        check_eq("i1_flash_row", 200'(flash_row_last), 200'(FL_ROW));

        // Four-row clear: rows 16..19 missing only x=0.
        clear_board();
        for (int y = 16; y < 20; y++) begin
            lock_piece(1, y, 2, y, 3, y, 4, y);
            lock_piece(5, y, 6, y, 7, y, 8, y);
            lock_piece(9, y, 15, 0, 15, 0, 15, 0);
        end
        lock_piece(0, 16, 0, 17, 0, 18, 0, 19);
        check_eq("i4_latency", 200'(lat), 200'(30 + 4 * FL));
        check_eq("i4_board", bus.boardMemory, '0);
        check_eq("i4_lines", 200'(bus.lines_cleared), 200'(4));

        // Overlap at (3,10) plus an out-of-range cell at Y=25.
        clear_board();
        lock_piece(3, 10, 15, 0, 15, 0, 15, 0);
        lock_piece(3, 10, 4, 10, 5, 10, 5, 25);
        exp_board = '0;
        exp_board[103] = 1'b1; exp_board[104] = 1'b1; exp_board[105] = 1'b1;
        check_eq("conf_conflict", 200'(bus.conflict), 200'(1));
        check_eq("conf_board", bus.boardMemory, exp_board);
        check_eq("conf_lines", 200'(bus.lines_cleared), 200'(0));
        check_eq("conf_latency", 200'(lat), 200'(22));

        // Second lock_req while busy must be dropped.
        clear_board();
        @(negedge clk);
        set_coords(0, 0, 1, 0, 2, 0, 3, 0);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        check_eq("busy_after_accept", 200'(bus.busy), 200'(1));
        check_eq("conflict_cleared_on_accept", 200'(bus.conflict), 200'(0));
        repeat (3) @(negedge clk);
        set_coords(7, 5, 8, 5, 7, 6, 8, 6);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        exp_board = '0;
        exp_board[0] = 1'b1; exp_board[1] = 1'b1; exp_board[2] = 1'b1; exp_board[3] = 1'b1;
        check_eq("busy_drop_done_count", 200'(done_cnt), 200'(1));
        check_eq("busy_drop_board", bus.boardMemory, exp_board);

        // board_clear wins over a simultaneous lock_req.
        @(negedge clk);
        set_coords(2, 2, 3, 2, 4, 2, 5, 2);
        bus.lock_req = 1'b1;
        bus.board_clear = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
        bus.board_clear = 1'b0;
        check_eq("clr_lock_board", bus.boardMemory, '0);
        check_eq("clr_lock_busy", 200'(bus.busy), 200'(0));
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check_eq("clr_lock_no_done", 200'(done_cnt), 200'(0));

        // Reset while the first SHIFT is in progress.
        fill_row19_but_x9();
        @(negedge clk);
        set_coords(9, 16, 9, 17, 9, 18, 9, 19);
        bus.lock_req = 1'b1;
        @(negedge clk);
        bus.lock_req = 1'b0;
`ifdef CLEAR_FLASH_EN
        repeat (1 + FL) @(negedge clk);
`else
        @(negedge clk);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_shift_board", bus.boardMemory, '0);
        check_eq("rst_shift_busy", 200'(bus.busy), 200'(0));
        check_eq("rst_shift_done", 200'(bus.done), 200'(0));
        rst = 1'b0;

        lock_piece(4, 18, 5, 18, 4, 19, 5, 19);
        exp_board = '0;
        exp_board[184] = 1'b1; exp_board[185] = 1'b1;
        exp_board[194] = 1'b1; exp_board[195] = 1'b1;
        check_eq("post_rst_board", bus.boardMemory, exp_board);
        check_eq("post_rst_latency", 200'(lat), 200'(22));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
